// File: rtl/byte_packer_if.sv
// ---------------------------------------------------------------------------
// | Interface : byte_packer_if                                              |
// | Purpose   : byte-side and word-side valid/ready bundle of byte_packer.  |
// |             The slave modport is the packer; master is the peer logic   |
// |             that feeds bytes and consumes words.                        |
// | Revision  : 1.0  initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

interface byte_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [2:0]  out_count;

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_count
  );

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_word, out_count
  );
endinterface

`default_nettype wire

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// | Module    : byte_packer                                                 |
// | Purpose   : packs a byte stream into 32-bit words (first byte in the    |
// |             most significant lane), with partial-word flush on in_last. |
// |             Unwritten lanes of a partial word carry PAD_BYTE.           |
// | Options   : BYTE_PACKER_LE_EN - little-endian lane order (byte k in     |
// |             bits [8k+7:8k]); padding still fills the lanes after the    |
// |             last written byte.                                          |
// | Revision  : 1.0  initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module byte_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  byte_packer_if.slave  bus
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_word;
  logic [2:0]  r_count;

  logic        w_out_valid;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_complete;
  logic        w_drain;
  logic [31:0] w_word;
  logic [31:0] w_acc_set;

  // Output holds a word exactly while the FSM sits in HOLD.
  assign w_out_valid = (r_state == HOLD);
  // Room for a byte whenever the output slot is empty or being emptied; never during reset.
  assign w_in_ready  = !reset && (!w_out_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_complete  = w_accept && ((r_cnt == 2'd3) || bus.in_last);
  assign w_drain     = w_out_valid && bus.out_ready;

  // Per-lane merge: lanes below cnt come from the accumulator, lane cnt takes the
  // incoming byte, lanes above cnt are padding in a completed word.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] c_LANE = 2'(k);
`ifdef BYTE_PACKER_LE_EN
    localparam int c_LO = 8 * k;
`else
    localparam int c_LO = 24 - 8 * k;
`endif
    assign w_word[c_LO +: 8]    = (c_LANE < r_cnt)  ? r_acc[c_LO +: 8] :
                                  (c_LANE == r_cnt) ? bus.in_byte      : PAD_BYTE;
    assign w_acc_set[c_LO +: 8] = (c_LANE == r_cnt) ? bus.in_byte : r_acc[c_LO +: 8];
  end

  // Next-state: complete fills HOLD, drain without a new completion returns to FILL.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (w_complete) w_state_next = HOLD;
      HOLD:    if (w_drain && !w_complete) w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  // State register, lane counter, accumulator and output word registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
      r_cnt   <= 2'd0;
      r_acc   <= 32'd0;
      r_word  <= 32'd0;
      r_count <= 3'd0;
    end else begin
      r_state <= w_state_next;
      if (w_complete) begin
        r_word  <= w_word;
        r_count <= {1'b0, r_cnt} + 3'd1;
        r_cnt   <= 2'd0;
        r_acc   <= 32'd0;
      end else if (w_accept) begin
        r_acc   <= w_acc_set;
        r_cnt   <= r_cnt + 2'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_word  = r_word;
  assign bus.out_count = r_count;

endmodule

`default_nettype wire
